// File: rtl/id_ex_stage.sv
// Decode/execute pipeline register: decodes one instruction into ALU operands and opcode,
// and holds them behind a valid/ready handshake. Optional macro ID_EX_FWD_EN adds the EX/MEM forward path.
module id_ex_stage #(
    parameter bit ILLEGAL_KILL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
`ifdef ID_EX_FWD_EN
    input  logic        fwd_valid,
    input  logic [4:0]  fwd_rd,
    input  logic [31:0] fwd_data,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] dataA,
    output logic [31:0] dataB,
    output logic [2:0]  alu_op,
    output logic [1:0]  cmp_sel,
    output logic [2:0]  funct3,
    output logic [4:0]  rd,
    output logic        reg_write,
    output logic        illegal
);
    localparam logic [6:0] OPC_OP = 7'b0110011, OPC_IMM = 7'b0010011, OPC_LUI = 7'b0110111,
                           OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111, OPC_JALR = 7'b1100111,
                           OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011, OPC_BRANCH = 7'b1100011;
    localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_OR = 3'b010, ALU_XOR = 3'b011,
                           ALU_AND = 3'b100, ALU_SRA = 3'b101, ALU_SRL = 3'b110, ALU_SLL = 3'b111;

    logic [6:0]  opcode, funct7;
    logic [2:0]  f3;
    logic [4:0]  rd_f, rs1_f, rs2_f;
    logic [31:0] imm_i, imm_s, imm_u, src1, src2, b_full;
    logic [4:0]  shamt;
    logic [31:0] d_a, d_b;
    logic [2:0]  d_op;
    logic [1:0]  d_cmp;
    logic        d_wr, d_ill, d_arith, d_alt, capture;

    assign opcode = instr[6:0];
    assign rd_f   = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1_f  = instr[19:15];
    assign rs2_f  = instr[24:20];
    assign funct7 = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u  = {instr[31:12], 12'h000};

`ifdef ID_EX_FWD_EN
    assign src1 = (fwd_valid && fwd_rd != 5'd0 && fwd_rd == rs1_f) ? fwd_data : rs1_data;
    assign src2 = (fwd_valid && fwd_rd != 5'd0 && fwd_rd == rs2_f) ? fwd_data : rs2_data;
`else
    assign src1 = rs1_data;
    assign src2 = rs2_data;
`endif

    // OP and OP-IMM share the funct3 decode; they differ in B source, shift amount and bit30 use
    assign b_full = (opcode == OPC_OP) ? src2 : imm_i;
    assign shamt  = (opcode == OPC_OP) ? src2[4:0] : rs2_f;
    assign d_alt  = instr[30] && ((opcode == OPC_OP) || (f3 == 3'b101));

    always_comb begin
        d_a     = '0;
        d_b     = '0;
        d_op    = ALU_ADD;
        d_cmp   = 2'b00;
        d_wr    = 1'b0;
        d_ill   = 1'b0;
        d_arith = 1'b0;
        case (opcode)
            OPC_OP:     if (funct7 == 7'b0000000 || funct7 == 7'b0100000) d_arith = 1'b1;
                        else d_ill = 1'b1;
            OPC_IMM:    d_arith = 1'b1;
            OPC_LUI:    begin d_b = imm_u; d_wr = 1'b1; end
            OPC_AUIPC:  begin d_a = pc; d_b = imm_u; d_wr = 1'b1; end
            OPC_JAL,
            OPC_JALR:   begin d_a = pc; d_b = 32'd4; d_wr = 1'b1; end
            OPC_LOAD:   begin d_a = src1; d_b = imm_i; d_wr = 1'b1; end
            OPC_STORE:  begin d_a = src1; d_b = imm_s; end
            OPC_BRANCH: begin d_a = src1; d_b = src2; d_op = ALU_SUB; d_cmp = 2'b11; end
            default:    d_ill = 1'b1;
        endcase
        if (d_arith) begin
            d_a  = src1;
            d_b  = b_full;
            d_wr = 1'b1;
            case (f3)
                3'b000: d_op = d_alt ? ALU_SUB : ALU_ADD;
                3'b001: begin d_op = ALU_SLL; d_b = {27'b0, shamt}; end
                3'b010: begin d_op = ALU_SUB; d_cmp = 2'b01; end
                3'b011: begin d_op = ALU_SUB; d_cmp = 2'b10; end
                3'b100: d_op = ALU_XOR;
                3'b101: begin d_op = d_alt ? ALU_SRA : ALU_SRL; d_b = {27'b0, shamt}; end
                3'b110: d_op = ALU_OR;
                default: d_op = ALU_AND;
            endcase
        end
        if (rd_f == 5'd0) d_wr = 1'b0;
    end

    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            dataA     <= '0;
            dataB     <= '0;
            alu_op    <= ALU_ADD;
            cmp_sel   <= 2'b00;
            funct3    <= '0;
            rd        <= '0;
            reg_write <= 1'b0;
            illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            illegal   <= 1'b0;
        end else if (capture) begin
            out_valid <= ILLEGAL_KILL ? !d_ill : 1'b1;
            dataA     <= d_a;
            dataB     <= d_b;
            alu_op    <= d_op;
            cmp_sel   <= d_cmp;
            funct3    <= f3;
            rd        <= rd_f;
            reg_write <= d_wr;
            illegal   <= d_ill;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed cases then randomized traffic against a reference model.
module tb_id_ex_stage;
    localparam bit KILL = 1'b1;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] instr, pc, rs1_data, rs2_data;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        in_ready, out_valid, reg_write, illegal;
    logic [31:0] dataA, dataB;
    logic [2:0]  alu_op, funct3;
    logic [1:0]  cmp_sel;
    logic [4:0]  rd;

    id_ex_stage #(.ILLEGAL_KILL(KILL)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
`ifdef ID_EX_FWD_EN
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .dataA(dataA), .dataB(dataB),
        .alu_op(alu_op), .cmp_sel(cmp_sel), .funct3(funct3), .rd(rd),
        .reg_write(reg_write), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a, b;
        logic [2:0]  op;
        logic [1:0]  cmp;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        wr, ill;
    } pkt_t;

    pkt_t m;
    logic m_valid;
    int   n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ALU meaning of register/immediate arithmetic, keyed by funct3
    function automatic pkt_t arith(input pkt_t p, input logic [2:0] f3, input logic alt,
                                   input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        pkt_t e = p;
        e.a = a; e.b = b; e.wr = 1'b1;
        case (f3)
            3'd0: e.op = alt ? 3'd1 : 3'd0;
            3'd1: begin e.op = 3'd7; e.b = 32'(sh); end
            3'd2: begin e.op = 3'd1; e.cmp = 2'd1; end
            3'd3: begin e.op = 3'd1; e.cmp = 2'd2; end
            3'd4: e.op = 3'd3;
            3'd5: begin e.op = alt ? 3'd5 : 3'd6; e.b = 32'(sh); end
            3'd6: e.op = 3'd2;
            default: e.op = 3'd4;
        endcase
        return e;
    endfunction

    function automatic pkt_t ref_pkt();
        pkt_t e = '0;
        logic [31:0] s1 = rs1_data, s2 = rs2_data;
        logic [31:0] ii = 32'($signed(instr[31:20]));
        logic [31:0] si = 32'($signed({instr[31:25], instr[11:7]}));
        logic [31:0] ui = instr & 32'hFFFF_F000;
`ifdef ID_EX_FWD_EN
        if (fwd_valid && fwd_rd != 0) begin
            if (fwd_rd == instr[19:15]) s1 = fwd_data;
            if (fwd_rd == instr[24:20]) s2 = fwd_data;
        end
`endif
        e.f3 = instr[14:12];
        e.rd = instr[11:7];
        case (instr[6:0])
            7'b0110011: if (instr[31:25] == 7'h00 || instr[31:25] == 7'h20)
                            e = arith(e, e.f3, instr[30], s1, s2, s2[4:0]);
                        else e.ill = 1'b1;
            7'b0010011: e = arith(e, e.f3, instr[30] && e.f3 == 3'd5, s1, ii, instr[24:20]);
            7'b0110111: begin e.b = ui; e.wr = 1'b1; end
            7'b0010111: begin e.a = pc; e.b = ui; e.wr = 1'b1; end
            7'b1101111, 7'b1100111: begin e.a = pc; e.b = 4; e.wr = 1'b1; end
            7'b0000011: begin e.a = s1; e.b = ii; e.wr = 1'b1; end
            7'b0100011: begin e.a = s1; e.b = si; end
            7'b1100011: begin e.a = s1; e.b = s2; e.op = 3'd1; e.cmp = 2'd3; end
            default: e.ill = 1'b1;
        endcase
        if (e.rd == 0) e.wr = 1'b0;
        return e;
    endfunction

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("illegal", 32'(illegal), 32'(m.ill));
        if (m_valid) begin
            chk("dataA", dataA, m.a);
            chk("dataB", dataB, m.b);
            chk("alu_op", 32'(alu_op), 32'(m.op));
            chk("cmp_sel", 32'(cmp_sel), 32'(m.cmp));
            chk("funct3", 32'(funct3), 32'(m.f3));
            chk("rd", 32'(rd), 32'(m.rd));
            chk("reg_write", 32'(reg_write), 32'(m.wr));
        end
    endtask

    task automatic check_reset();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_a", dataA, 0);
        chk("rst_b", dataB, 0);
        chk("rst_ctl", {alu_op, cmp_sel, funct3, rd, reg_write, illegal}, 0);
    endtask

    // Inputs are set near the falling edge; this advances one rising edge and checks the result
    task automatic cycle();
        pkt_t e;
        #1 chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
        @(posedge clk);
        if (flush) begin
            m_valid = 1'b0;
            m.ill   = 1'b0;
        end else if (in_valid && (!m_valid || out_ready)) begin
            e       = ref_pkt();
            m       = e;
            m_valid = !(e.ill && KILL);
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic put(input logic v, input logic [31:0] i, input logic [31:0] r1,
                       input logic [31:0] r2, input logic ordy);
        in_valid = v; instr = i; rs1_data = r1; rs2_data = r2; out_ready = ordy;
    endtask

    localparam logic [31:0] ADD_I = {7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
    localparam logic [31:0] SUB_I = {7'h20, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
    localparam logic [31:0] SRAI_I = {7'h20, 5'd31, 5'd2, 3'b101, 5'd1, 7'b0010011};
    localparam logic [31:0] SLL_I = {7'h00, 5'd2, 5'd1, 3'b001, 5'd3, 7'b0110011};

    logic [6:0] opc_tab [10];

    initial begin
        opc_tab = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
                    7'b1100111, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1111111};
        m = '0; m_valid = 1'b0;
        rst_n = 1'b0; flush = 1'b0; pc = 32'h0000_1000;
        fwd_valid = 1'b0; fwd_rd = 5'd0; fwd_data = 32'd0;
        put(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        #12 check_reset();
        @(negedge clk) rst_n = 1'b1;

        put(1'b1, ADD_I, 32'd5, 32'd7, 1'b1); cycle();
        chk("add_op", 32'(alu_op), 0); chk("add_a", dataA, 5); chk("add_b", dataB, 7);
        put(1'b1, SUB_I, 32'd5, 32'd7, 1'b1); cycle();
        chk("sub_op", 32'(alu_op), 1);
        put(1'b1, SRAI_I, 32'h8000_0000, 32'h1234_5678, 1'b1); cycle();
        chk("srai_op", 32'(alu_op), 5); chk("srai_b", dataB, 31);
        put(1'b1, SLL_I, 32'h1, 32'hFFFF_FFE3, 1'b1); cycle();
        chk("sll_op", 32'(alu_op), 7); chk("sll_b", dataB, 3);

        put(1'b1, ADD_I, 32'd1, 32'd2, 1'b1); cycle();
        for (int k = 0; k < 3; k++) begin
            put(1'b1, SUB_I, 32'd9, 32'd9, 1'b0); cycle();
            chk("stall_ready", 32'(in_ready), 0); chk("stall_a", dataA, 1);
        end
        put(1'b1, SUB_I, 32'd9, 32'd9, 1'b1); cycle();
        chk("release_op", 32'(alu_op), 1); chk("release_valid", 32'(out_valid), 1);

        flush = 1'b1; put(1'b1, ADD_I, 32'd3, 32'd4, 1'b1); cycle(); flush = 1'b0;
        chk("flush_valid", 32'(out_valid), 0);
        put(1'b1, 32'hFFFF_FFFF, 32'd3, 32'd4, 1'b1); cycle();
        chk("ill_valid", 32'(out_valid), 0); chk("ill_flag", 32'(illegal), 1);

        put(1'b1, ADD_I, 32'd5, 32'd7, 1'b0); cycle();
        put(1'b0, ADD_I, 32'd5, 32'd7, 1'b0); cycle();
        #2 rst_n = 1'b0;
        #1 check_reset();
        m = '0; m_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;

`ifdef ID_EX_FWD_EN
        fwd_valid = 1'b1; fwd_rd = 5'd1; fwd_data = 32'hAA;
        put(1'b1, ADD_I, 32'd0, 32'd7, 1'b1); cycle();
        chk("fwd_hit_a", dataA, 32'hAA);
        fwd_rd = 5'd0;
        put(1'b1, ADD_I, 32'd0, 32'd7, 1'b1); cycle();
        chk("fwd_x0_a", dataA, 0);
        fwd_valid = 1'b0;
`endif

        for (int n = 0; n < 600; n++) begin
            logic [31:0] r;
            int k;
            r = $urandom;
            k = $urandom_range(0, 10);
            if (k < 10) r[6:0] = opc_tab[k];
            if (k == 0 && $urandom_range(0, 1) == 1) r[31:25] = {1'b0, r[30], 5'b0};
            pc        = $urandom & 32'hFFFF_FFFC;
            fwd_valid = $urandom_range(0, 1) == 1;
            fwd_rd    = 5'($urandom_range(0, 3));
            fwd_data  = $urandom;
            flush     = $urandom_range(0, 19) == 0;
            put($urandom_range(0, 3) != 0, r, $urandom, $urandom, $urandom_range(0, 9) < 7);
            cycle();
        end
        flush = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode/execute pipeline register for the RISC-V core: accepts one decoded-fetch packet (instruction, PC, register-file read data), builds the ALU operands and the 3-bit ALU opcode, and holds them stable for the 32-bit ALU. It sits directly upstream of the ALU and owns the valid/ready handshake, flush and stall behaviour for that boundary.

## Interface
- `ILLEGAL_KILL`, default 1: 1 = an illegal instruction is captured as a bubble (`out_valid`=0, `illegal`=1); 0 = it passes with `out_valid`=1, `illegal`=1.
- `clk` in 1: the single clock; all state is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: kills the held and incoming packet.
- `in_valid` in 1 / `in_ready` out 1: upstream handshake.
- `instr` in 32: raw instruction.
- `pc` in 32: its address.
- `rs1_data`, `rs2_data` in 32 each: register-file read data.
- `fwd_valid` in 1, `fwd_rd` in 5, `fwd_data` in 32: EX/MEM forward path. Present only with `ID_EX_FWD_EN`.
- `out_valid` out 1 / `out_ready` in 1: downstream handshake.
- `dataA`, `dataB` out 32: ALU operands.
- `alu_op` out 3: ADD 000, SUB 001, OR 010, XOR 011, AND 100, SRA 101, SRL 110, SLL 111.
- `cmp_sel` out 2: 00 = use `alu_out_data`; 01 = signed slt; 10 = unsigned slt; 11 = branch compare.
- `funct3` out 3, `rd` out 5, `reg_write` out 1, `illegal` out 1: passed to later stages.

## Operation
- **Opcode map.** Operands and op are decoded combinationally from `instr` and captured on the handshake.
  - OP 0110011: A=rs1, B=rs2. ADD/SUB chosen by bit30. SLL, SRL/SRA by bit30. XOR, OR, AND.
  - OP-IMM 0010011: B = sign-extended I-immediate. SUBI does not exist; bit30 is honoured only for SRAI.
  - SLT/SLTI/SLTU/SLTIU: alu_op=001, cmp_sel=01 or 10.
  - Shifts (reg or imm): dataB = {27'b0, shamt[4:0]}. Upper bits are always zeroed.
  - LUI: A=0, B=U-imm, ADD.
  - AUIPC: A=pc, B=U-imm, ADD.
  - JAL/JALR: A=pc, B=4, ADD, reg_write=1.
  - LOAD: A=rs1, B=I-imm, ADD.
  - STORE: A=rs1, B=S-imm, ADD, reg_write=0.
  - BRANCH: A=rs1, B=rs2, SUB, cmp_sel=11, reg_write=0.
  - Any other opcode, and OP with funct7 not in {0000000, 0100000}, is illegal: alu_op=000, A=B=0, reg_write=0.
- **Write-back rule.** `reg_write` is forced to 0 whenever rd=0.
- **Handshake.**
  - Capture occurs when `in_valid && in_ready && !flush`.
  - `in_ready = !out_valid || out_ready` (combinational, no bubble on continuous flow).
  - Downstream consumes when `out_valid && out_ready`. With no new capture in that cycle, `out_valid` clears on the next edge.
- **Stall.** While `out_valid && !out_ready`, all outputs hold bit-stable.

## Timing
- Latency: 1 cycle from accepted input to `out_valid`. Throughput is 1 packet/cycle.
- Reset (async assert, sync-safe deassert): `out_valid`=0, `dataA`=`dataB`=0, `alu_op`=000, `cmp_sel`=00, `funct3`=0, `rd`=0, `reg_write`=0, `illegal`=0. `in_ready`=1 while in reset.
- Reset mid-stall drops the held packet. No partial state survives.
- `flush` has priority over capture and over hold:
  - Next edge: `out_valid`=0 and `illegal`=0.
  - Input presented in the same cycle is discarded.
  - Data registers may keep stale values.
- Simultaneous consume and capture: the new packet replaces the old on the same edge.
- `in_ready` is low only when holding a packet that downstream refuses.

## Configuration
- `ID_EX_FWD_EN`:
  - Defined: forward ports exist. When `fwd_valid` is high and `fwd_rd` is nonzero and equals rs1 (or rs2), `fwd_data` replaces `rs1_data` (or `rs2_data`) before operand selection, checked independently for each source.
  - Undefined: ports are absent and register-file data is used directly.

## Test plan
- Reset while `out_valid`=1 and stalled -> all outputs go to their reset values immediately; `in_ready`=1.
- ADD x3,x1,x2 (rs1=5, rs2=7), then SUB (bit30) -> alu_op 000, dataA=5, dataB=7; next packet alu_op 001. Each appears 1 cycle after acceptance.
- SRAI x1,x2,31 with rs2 field bits set, and SLL with rs2_data=0xFFFF_FFE3 -> alu_op 101, dataB=31; alu_op 111, dataB=3.
- Hold `out_ready`=0 for 3 cycles with `in_valid`=1 -> `in_ready`=0, outputs unchanged. Release -> the next packet is captured on the same edge as consume.
- `flush` together with `in_valid`, and opcode 1111111 with ILLEGAL_KILL=1 -> `out_valid`=0 after both; illegal case shows `illegal`=1.
- With ID_EX_FWD_EN: fwd_rd=1, fwd_data=0xAA, rs1=x1, rs1_data=0 -> dataA=0xAA. With fwd_rd=0 -> dataA=0.
